dram_bram_responder: RTL and testbench
======================================

# dram_bram_responder

Single-clock, BRAM-backed responder for the DRAM command interface (cmd_en/rnw/address/wr_data/wr_be in; ack/rd_data/rd_dvld out). It stands in for the DDR2 controller in simulation and in DRAM-less builds. OPB-to-DRAM bridges and other DRAM initiators can then run unchanged against on-chip memory. Each address maps to one 288-bit burst, transferred as two 144-bit beats.

## Interface
- ADDR_BITS, 8: number of low address bits decoded; depth is 2^ADDR_BITS bursts (2^(ADDR_BITS+1) 144-bit words).
- RD_LATENCY, 4: cycles from read ack to first rd_dvld; legal range 1..15.
- ACK_DELAY, 2: cycles cmd_en must be held in IDLE before ack; legal range 0..15.

Ports:
- dram_clk  in  1  sole clock; all logic on the rising edge.
- dram_rst  in  1  reset; synchronous and active-high.
- dram_cmd_en  in  1  command request; held by the initiator until it sees ack.
- dram_cmd_rnw  in  1  1 = read burst, 0 = write burst.
- dram_address  in  32  burst address; only [ADDR_BITS-1:0] is used, upper bits are ignored (aliasing).
- dram_wr_data  in  144  write data for the current beat.
- dram_wr_be  in  18  byte enables; bit i qualifies wr_data[8i+7:8i].
- dram_ack  out  1  command accepted; combinational, only while cmd_en=1.
- dram_rd_data  out  144  read beat data; zero when rd_dvld=0.
- dram_rd_dvld  out  1  read beat valid; high for exactly 2 consecutive cycles per read.
- protocol_err  out  1  sticky initiator-violation flag.

## Operation
- Storage: array mem[{addr, beat}], 144 bits per word. Contents are not reset and are X until written.
- FSM states:
  - IDLE: waits for cmd_en; on ack goes to WR1 if rnw=0, or RD_WAIT if rnw=1.
  - WR1: always returns to IDLE after one cycle.
  - RD_WAIT: counts RD_LATENCY-1 cycles, then goes to RD0 (when RD_LATENCY=1, goes directly to RD0).
  - RD0 -> RD1 -> IDLE.
- Hold counter (4-bit), IDLE only:
  - Increments each cycle cmd_en=1 without ack.
  - Clears on ack, on cmd_en=0, or outside IDLE.
  - ack = cmd_en && state==IDLE && hold_cnt==ACK_DELAY.
- Address and rnw are captured at the ack cycle into addr_q and rnw_q.
- Write handling:
  - Ack cycle: beat 0 is written per byte, mem[{addr,0}] byte i <= wr_data byte i where wr_be[i]=1.
  - WR1 cycle: beat 1 is written to mem[{addr_q,1}] using that cycle's wr_data and wr_be.
  - A be of all zeros in either beat is legal and writes nothing.
- Read handling:
  - Array read is registered.
  - RD0 drives mem[{addr_q,0}] with rd_dvld=1.
  - RD1 drives mem[{addr_q,1}] with rd_dvld=1.
  - rd_data is forced to 0 otherwise.
- protocol_err is set, and held until dram_rst, when either occurs in IDLE with hold_cnt>0:
  - cmd_en falls before ack (abandoned command).
  - rnw or address changes from the previous cycle while cmd_en is held.
  - Both cases are still serviced/dropped normally; the flag is diagnostic only.
- cmd_en asserted outside IDLE: no ack, the hold counter does not run, and the command waits. This is not an error.

## Timing
- Reset values: ack=0 (state IDLE), rd_dvld=0, rd_data=0, protocol_err=0, hold_cnt=0.
- Reset mid-burst: FSM returns to IDLE. A pending beat-1 write is not performed; pending read beats are not issued.
- Ack timing: command first presented at cycle T in IDLE gets ack at T+ACK_DELAY. With ACK_DELAY=0, ack is in the same cycle.
- Write ack at cycle C:
  - Beat 0 is stored at the end of C and beat 1 at the end of C+1.
  - The earliest next ack is C+2 (with ACK_DELAY=0).
- Read ack at cycle C:
  - rd_dvld is high in C+RD_LATENCY and C+RD_LATENCY+1, carrying beat 0 then beat 1.
  - The earliest next ack is C+RD_LATENCY+2.
- Read after write: a read acked at C+2 after a write acked at C returns the new data. No bypass is needed, since beat 1 is committed at the end of C+1.
- Address wrap: address 2^ADDR_BITS aliases address 0.

## Test plan
- Reset with ACK_DELAY=2 -> all outputs 0. Then cmd_en=1, rnw=0 from T -> ack exactly at T+2, no ack at T or T+1.
- Write addr 0x5:
  - Stimulus: beat 0 data 0x…AA with be=0x3FFFF, then beat 1 data 0x…BB with be=0x00001.
  - Then read addr 0x5 with RD_LATENCY=4.
  - Required: dvld at ack+4 and ack+5; data 0x…AA, then beat 1 with only byte 0 = 0xBB and the rest X/prior contents.
- Back-to-back: write ack at C, read of the same address held from C+1 -> read ack at C+2 (ACK_DELAY=0), returns the written beats; rd_data=0 outside dvld.
- Read at 0x100 with ADDR_BITS=8 after a write at 0x000 -> returns 0x000 data (wrap).
- cmd_en dropped at hold_cnt=1 -> protocol_err=1, sticky through later good transactions until dram_rst. rnw toggled mid-hold -> same result.
- dram_rst asserted in RD_WAIT -> no rd_dvld pulses afterwards. The next command is acked from IDLE after ACK_DELAY.

Source files
------------

// File: rtl/dram_bram_responder.sv
// dram_bram_responder: BRAM stand-in for the DRAM command port (clk/rst, cmd_en/rnw/address/wr_data/wr_be in; ack/rd_data/rd_dvld/protocol_err out)
module dram_bram_responder #(
  parameter int ADDR_BITS  = 8,
  parameter int RD_LATENCY = 4,
  parameter int ACK_DELAY  = 2
) (
  input  logic         dram_clk,
  input  logic         dram_rst,
  input  logic         dram_cmd_en,
  input  logic         dram_cmd_rnw,
  input  logic [31:0]  dram_address,
  input  logic [143:0] dram_wr_data,
  input  logic [17:0]  dram_wr_be,
  output logic         dram_ack,
  output logic [143:0] dram_rd_data,
  output logic         dram_rd_dvld,
  output logic         protocol_err
);
  typedef enum logic [2:0] {IDLE, WR1, RD_WAIT, RD0, RD1} state_t;
  state_t state, nxt;
  logic [3:0] hold_cnt, lat_cnt;
  logic [ADDR_BITS-1:0] addr_q, addr_in;
  logic [ADDR_BITS:0] wa, ra;
  logic [143:0] mem [2**(ADDR_BITS+1)];
  logic [143:0] rd_q;
  logic [31:0] prev_addr;
  logic prev_rnw, we;
  assign addr_in = dram_address[ADDR_BITS-1:0];
  always_comb begin
    nxt = state;
    dram_ack = dram_cmd_en && state == IDLE && hold_cnt == 4'(ACK_DELAY);
    case (state)
      IDLE:    if (dram_ack) nxt = !dram_cmd_rnw ? WR1 : (RD_LATENCY == 1 ? RD0 : RD_WAIT);
      WR1:     nxt = IDLE;
      RD_WAIT: nxt = lat_cnt == 4'(RD_LATENCY - 2) ? RD0 : RD_WAIT;
      RD0:     nxt = RD1;
      default: nxt = IDLE;
    endcase
    we = !dram_rst && ((dram_ack && !dram_cmd_rnw) || state == WR1);
    wa = dram_ack ? {addr_in, 1'b0} : {addr_q, 1'b1};
    ra = nxt == RD0 ? {dram_ack ? addr_in : addr_q, 1'b0} : {addr_q, 1'b1};
    dram_rd_dvld = state == RD0 || state == RD1;
    dram_rd_data = dram_rd_dvld ? rd_q : '0;
  end
  always_ff @(posedge dram_clk) begin
    if (dram_rst) begin
      state <= IDLE;
      hold_cnt <= '0;
      lat_cnt <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= nxt;
      hold_cnt <= (state == IDLE && dram_cmd_en && !dram_ack) ? hold_cnt + 4'd1 : 4'd0;
      lat_cnt <= state == RD_WAIT ? lat_cnt + 4'd1 : 4'd0;
      if (dram_ack) addr_q <= addr_in;
      if (state == IDLE && hold_cnt != 4'd0 &&
          (!dram_cmd_en || dram_cmd_rnw != prev_rnw || dram_address != prev_addr))
        protocol_err <= 1'b1;
    end
  end
  always_ff @(posedge dram_clk) begin
    prev_rnw <= dram_cmd_rnw;
    prev_addr <= dram_address;
    rd_q <= mem[ra];
    for (int i = 0; i < 18; i++)
      if (we && dram_wr_be[i]) mem[wa][8*i +: 8] <= dram_wr_data[8*i +: 8];
  end
endmodule

// File: tb/tb_dram_bram_responder.sv
// tb_dram_bram_responder: directed bench with a cycle-schedule reference model for dram_bram_responder
module tb_dram_bram_responder;
  localparam int AB = 8, RL = 4, AD = 2;
  logic clk = 1'b0, rst = 1'b1, cmd_en = 1'b0, rnw = 1'b0;
  logic [31:0] addr = '0;
  logic [143:0] wdata = '0;
  logic [17:0] be = '0;
  logic ack, dvld, perr;
  logic [143:0] rdata;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dram_bram_responder #(.ADDR_BITS(AB), .RD_LATENCY(RL), .ACK_DELAY(AD)) dut (
    .dram_clk(clk), .dram_rst(rst), .dram_cmd_en(cmd_en), .dram_cmd_rnw(rnw),
    .dram_address(addr), .dram_wr_data(wdata), .dram_wr_be(be),
    .dram_ack(ack), .dram_rd_data(rdata), .dram_rd_dvld(dvld), .protocol_err(perr));

  task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: memory of known bytes plus a schedule of when the responder is free,
  // when read beats are due and when the second write beat lands.
  logic [143:0] mm [512];
  logic [17:0] mk [512];
  int cyc = 0, free_c = 0, hold = 0, rd_c0 = -100, pend = -100;
  logic [AB-1:0] rd_a, pend_a;
  logic exp_err = 1'b0, prev_rnw = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [143:0] bmask(input logic [17:0] k);
    logic [143:0] m;
    for (int i = 0; i < 18; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic mwrite(input logic [AB:0] k, input logic [143:0] d, input logic [17:0] b);
    for (int i = 0; i < 18; i++)
      if (b[i]) begin
        mm[k][8*i +: 8] = d[8*i +: 8];
        mk[k][i] = 1'b1;
      end
  endtask

  always @(negedge clk) begin : cmp
    logic idle, e_ack, e_dv, err_n;
    logic [AB:0] k;
    if (rst) begin
      free_c = cyc + 1;
      hold = 0;
      rd_c0 = -100;
      pend = -100;
      exp_err = 1'b0;
    end else begin
      idle = cyc >= free_c;
      e_ack = cmd_en && idle && hold == AD;
      e_dv = cyc == rd_c0 || cyc == rd_c0 + 1;
      chki("ack", int'(ack), int'(e_ack));
      chki("rd_dvld", int'(dvld), int'(e_dv));
      chki("protocol_err", int'(perr), int'(exp_err));
      if (e_dv) begin
        k = {rd_a, 1'(cyc != rd_c0)};
        chk("rd_data", rdata & bmask(mk[k]), mm[k] & bmask(mk[k]));
      end else chk("rd_data_idle", rdata, '0);
      err_n = idle && hold > 0 && (!cmd_en || rnw != prev_rnw || addr != prev_addr);
      if (cyc == pend) mwrite({pend_a, 1'b1}, wdata, be);
      if (e_ack) begin
        hold = 0;
        if (rnw) begin
          rd_c0 = cyc + RL;
          rd_a = addr[AB-1:0];
          free_c = cyc + RL + 2;
        end else begin
          mwrite({addr[AB-1:0], 1'b0}, wdata, be);
          pend = cyc + 1;
          pend_a = addr[AB-1:0];
          free_c = cyc + 2;
        end
      end else hold = (idle && cmd_en) ? hold + 1 : 0;
      if (err_n) exp_err = 1'b1;
    end
    prev_rnw = rnw;
    prev_addr = addr;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    smp();
    while (!ack && n < 40) begin
      tick();
      smp();
      n++;
    end
    chki("ack_seen", int'(ack), 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [143:0] d0, input logic [17:0] b0,
                    input logic [143:0] d1, input logic [17:0] b1);
    int n;
    cmd_en = 1'b1; rnw = 1'b0; addr = a; wdata = d0; be = b0;
    wait_ack(n);
    tick();
    cmd_en = 1'b0; wdata = d1; be = b1;
    tick();
    be = '0;
  endtask

  task automatic rd_tail(output logic [143:0] b0, output logic [143:0] b1);
    tick();
    cmd_en = 1'b0; be = '0;
    repeat (RL - 1) tick();
    smp();
    chki("dvld_beat0", int'(dvld), 1);
    b0 = rdata;
    tick();
    smp();
    chki("dvld_beat1", int'(dvld), 1);
    b1 = rdata;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, output logic [143:0] b0, output logic [143:0] b1);
    int n;
    cmd_en = 1'b1; rnw = 1'b1; addr = a;
    wait_ack(n);
    rd_tail(b0, b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [143:0] b0, b1;
    int n, cnt;
    for (int i = 0; i < 512; i++) mk[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
    smp();
    chki("rst_ack", int'(ack), 0);
    chki("rst_dvld", int'(dvld), 0);
    chk("rst_rd_data", rdata, '0);
    chki("rst_perr", int'(perr), 0);
    tick();
    // ack appears exactly ACK_DELAY cycles after the command is first presented
    cmd_en = 1'b1; rnw = 1'b0; addr = 32'h5; wdata = {18{8'hAA}}; be = 18'h3FFFF;
    smp(); chki("ack_T0", int'(ack), 0);
    tick(); smp(); chki("ack_T1", int'(ack), 0);
    tick(); smp(); chki("ack_T2", int'(ack), 1);
    tick();
    cmd_en = 1'b0; wdata = {18{8'hBB}}; be = 18'h00001;
    tick();
    be = '0;
    rd(32'h5, b0, b1);
    chk("rd5_beat0", b0, {18{8'hAA}});
    chki("rd5_beat1_byte0", int'(b1[7:0]), 8'hBB);
    // write then a read of the same address held from the cycle after the write ack
    cmd_en = 1'b1; rnw = 1'b0; addr = 32'h22; wdata = {9{16'h1234}}; be = 18'h3FFFF;
    wait_ack(n);
    tick();
    wdata = {9{16'h5678}}; rnw = 1'b1;
    wait_ack(n);
    chki("b2b_ack_gap", n, AD + 1);
    rd_tail(b0, b1);
    chk("b2b_beat0", b0, {9{16'h1234}});
    chk("b2b_beat1", b1, {9{16'h5678}});
    // aliasing: 0x100 and 0x000 are the same burst
    wr(32'h0, {4'h0, {35{4'hC}}}, 18'h3FFFF, {36{4'h3}}, 18'h3FFFF);
    rd(32'h100, b0, b1);
    chk("wrap_beat0", b0, {4'h0, {35{4'hC}}});
    chk("wrap_beat1", b1, {36{4'h3}});
    // an all-zero byte enable leaves the old beat untouched
    wr(32'h7, {18{8'h77}}, 18'h3FFFF, {18{8'h66}}, 18'h3FFFF);
    wr(32'h7, {18{8'h99}}, 18'h00000, {18{8'h44}}, 18'h2AAAA);
    rd(32'h7, b0, b1);
    chk("be0_beat0", b0, {18{8'h77}});
    chk("be_beat1", b1, {9{16'h4466}});
    // abandoned command sets the sticky error
    cmd_en = 1'b1; rnw = 1'b0; addr = 32'h9; wdata = '0; be = '0;
    tick(); tick();
    cmd_en = 1'b0;
    tick(); smp();
    chki("abandon_perr", int'(perr), 1);
    tick();
    wr(32'h3, {18{8'h12}}, 18'h3FFFF, {18{8'h34}}, 18'h3FFFF);
    smp(); chki("perr_sticky", int'(perr), 1);
    tick();
    do_reset();
    smp(); chki("perr_cleared", int'(perr), 0);
    tick();
    // rnw change while held sets the error; the command is still serviced
    cmd_en = 1'b1; rnw = 1'b0; addr = 32'h3;
    tick();
    rnw = 1'b1;
    wait_ack(n);
    rd_tail(b0, b1);
    chk("toggle_rd_beat0", b0, {18{8'h12}});
    smp(); chki("toggle_perr", int'(perr), 1);
    tick();
    do_reset();
    // reset during the read wait drops the pending beats
    cmd_en = 1'b1; rnw = 1'b1; addr = 32'h5;
    wait_ack(n);
    tick();
    cmd_en = 1'b0;
    tick();
    do_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      smp();
      if (dvld) cnt++;
      tick();
    end
    chki("no_dvld_after_rst", cnt, 0);
    cmd_en = 1'b1; rnw = 1'b0; addr = 32'h11; wdata = {18{8'h5A}}; be = 18'h3FFFF;
    wait_ack(n);
    chki("post_rst_ack_delay", n, AD);
    tick();
    cmd_en = 1'b0; be = 18'h3FFFF;
    tick();
    be = '0;
    rd(32'h11, b0, b1);
    chk("post_rst_rd", b0, {18{8'h5A}});
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
